shifter_seq: RTL and testbench

- Parametrised, multi-cycle successor to the combinational 16-bit shifter in the SIMPLE datapath.
- Shifts a W-bit operand by up to STEP bit positions per clock and produces the result plus S/Z/C/V flags behind a start/busy/done handshake.
- Ops: SLL, SLR (rotate left), SRL and SRA.
- Sits in the execute stage beside the ALU. The controller stalls on busy and samples out/szcv on done.

---
 rtl/shifter_seq.sv | 165 ++++++++++++++++
 tb/tb_shifter_seq.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/shifter_seq.sv
// -----------------------------------------------------------------------------
// shifter_seq
//   Multi-cycle barrel-less shifter for the execute stage. Shifts a W-bit
//   operand by up to STEP positions per clock and reports {S,Z,C,V} flags
//   behind a start/busy/done handshake. The results match a one-shot shift
//   by d.
//
// Ports
//   clk    : clock, all state on rising edge
//   rst_n  : asynchronous active-low reset
//   start  : request, only looked at while idle
//   op     : 1000 SLL, 1001 SLR (rotate left), 1010 SRL, 1011 SRA, else no-op
//   br     : operand, captured with start
//   d      : shift amount 0..W-1, captured with start
//   busy   : high from the accepting edge through the done cycle
//   done   : one-cycle pulse, out/szcv valid in that cycle
//   out    : registered result
//   szcv   : registered {S,Z,C,V}
// -----------------------------------------------------------------------------
module shifter_seq #(
    parameter int W    = 16,
    parameter int STEP = 1,
    localparam int DW  = $clog2(W)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic [3:0]    op,
    input  logic [W-1:0]  br,
    input  logic [DW-1:0] d,
    output logic          busy,
    output logic          done,
    output logic [W-1:0]  out,
    output logic [3:0]    szcv
);

    localparam logic [DW-1:0] STEP_L = DW'(STEP);
    localparam logic [DW:0]   W_EXT  = (DW+1)'(W);

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    state_t        state_reg, state_next;
    logic [3:0]    op_reg, op_next;
    logic          msb_reg, msb_next;
    logic [W-1:0]  acc_reg, acc_next;
    logic [DW-1:0] rem_reg, rem_next;
    logic          c_reg, c_next;
    logic [W-1:0]  out_reg, out_next;
    logic [3:0]    szcv_reg, szcv_next;

    // Single-step shift datapath
    logic [DW-1:0] amt;
    logic [DW-1:0] back;
    logic [W-1:0]  step_acc;
    logic          step_c;
    logic          start_is_shift;

    assign start_is_shift = (op[3:2] == 2'b10);

    always_comb begin
        amt      = (rem_reg < STEP_L) ? rem_reg : STEP_L;
        // W - amt; amt is never 0 while shifting, so this stays in 1..W-1
        back     = DW'(W_EXT - {1'b0, amt});
        step_acc = acc_reg;
        step_c   = 1'b0;
        case (op_reg[1:0])
            2'b00: begin
                step_acc = acc_reg << amt;
                step_c   = acc_reg[back];
            end
            2'b01: begin
                step_acc = (acc_reg << amt) | (acc_reg >> back);
                step_c   = 1'b0;
            end
            2'b10: begin
                step_acc = acc_reg >> amt;
                step_c   = acc_reg[amt - DW'(1)];
            end
            default: begin
                // Arithmetic right: fill from the sign bit captured at start
                step_acc = (acc_reg >> amt) | ({W{msb_reg}} << back);
                step_c   = acc_reg[amt - DW'(1)];
            end
        endcase
    end

    always_comb begin
        state_next = state_reg;
        op_next    = op_reg;
        msb_next   = msb_reg;
        acc_next   = acc_reg;
        rem_next   = rem_reg;
        c_next     = c_reg;
        out_next   = out_reg;
        szcv_next  = szcv_reg;
        case (state_reg)
            IDLE: begin
                if (start) begin
                    op_next  = op;
                    msb_next = br[W-1];
                    acc_next = br;
                    rem_next = d;
                    c_next   = 1'b0;
                    if (start_is_shift && (d != '0)) begin
                        state_next = SHIFT;
                    end else begin
                        // Zero-length shift or non-shift op: result is ready now
                        state_next = DONE;
                        if (start_is_shift) begin
                            out_next  = br;
                            szcv_next = {br[W-1], (br == '0), 2'b00};
                        end else begin
                            out_next  = '0;
                            szcv_next = 4'b0000;
                        end
                    end
                end
            end
            SHIFT: begin
                acc_next = step_acc;
                rem_next = rem_reg - amt;
                c_next   = step_c;
                if (rem_reg == amt) begin
                    state_next = DONE;
                    out_next   = step_acc;
                    szcv_next  = {step_acc[W-1], (step_acc == '0), step_c, 1'b0};
                end
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
            op_reg    <= '0;
            msb_reg   <= 1'b0;
            acc_reg   <= '0;
            rem_reg   <= '0;
            c_reg     <= 1'b0;
            out_reg   <= '0;
            szcv_reg  <= '0;
        end else begin
            state_reg <= state_next;
            op_reg    <= op_next;
            msb_reg   <= msb_next;
            acc_reg   <= acc_next;
            rem_reg   <= rem_next;
            c_reg     <= c_next;
            out_reg   <= out_next;
            szcv_reg  <= szcv_next;
        end
    end

    assign busy = (state_reg != IDLE);
    assign done = (state_reg == DONE);
    assign out  = out_reg;
    assign szcv = szcv_reg;

endmodule

// File: tb/tb_shifter_seq.sv
// -----------------------------------------------------------------------------
// tb_shifter_seq
//   Drives two shifter_seq instances (STEP=1 and STEP=4) with identical
//   requests and checks each against a one-shot shift reference model,
//   including done latency, busy timing, output hold and ignored starts.
// -----------------------------------------------------------------------------
module tb_shifter_seq;

    localparam int W = 16;
    localparam int STEP_A = 1;
    localparam int STEP_B = 4;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [3:0]  op;
    logic [15:0] br;
    logic [3:0]  d;
    logic        busy_o [2];
    logic        done_o [2];
    logic [15:0] out_o  [2];
    logic [3:0]  szcv_o [2];

    int          n_cmp;
    int          n_fail;
    logic [15:0] last_out  [2];
    logic [3:0]  last_szcv [2];
    int          steps [2];

    shifter_seq #(.W(W), .STEP(STEP_A)) u_a (
        .clk(clk), .rst_n(rst_n), .start(start), .op(op), .br(br), .d(d),
        .busy(busy_o[0]), .done(done_o[0]), .out(out_o[0]), .szcv(szcv_o[0])
    );

    shifter_seq #(.W(W), .STEP(STEP_B)) u_b (
        .clk(clk), .rst_n(rst_n), .start(start), .op(op), .br(br), .d(d),
        .busy(busy_o[1]), .done(done_o[1]), .out(out_o[1]), .szcv(szcv_o[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One-shot shift reference
    function automatic void model(input logic [3:0] o, input logic [15:0] b,
                                  input int dd, output logic [15:0] r,
                                  output logic [3:0] f);
        logic c;
        c = 1'b0;
        r = 16'h0000;
        if (o[3:2] != 2'b10) begin
            f = 4'b0000;
            return;
        end
        case (o[1:0])
            2'b00: begin
                r = b << dd;
                if (dd != 0) c = b[16 - dd];
            end
            2'b01: r = (dd == 0) ? b : ((b << dd) | (b >> (16 - dd)));
            2'b10: begin
                r = b >> dd;
                if (dd != 0) c = b[dd - 1];
            end
            default: begin
                r = 16'($signed(b) >>> dd);
                if (dd != 0) c = b[dd - 1];
            end
        endcase
        f = {r[15], (r == 16'h0000), c, 1'b0};
    endfunction

    // Issue one request at the current negedge and follow both DUTs until idle.
    task automatic run_op(input string name, input logic [3:0] o,
                          input logic [15:0] b, input logic [3:0] dd,
                          input bit interfere);
        logic [15:0] er;
        logic [3:0]  ef;
        int          lat [2];
        int          maxl;
        int          minl;
        model(o, b, int'(dd), er, ef);
        for (int i = 0; i < 2; i++)
            lat[i] = (o[3:2] == 2'b10 && dd != 0) ? (int'(dd) + steps[i] - 1) / steps[i] : 0;
        maxl = (lat[0] > lat[1]) ? lat[0] : lat[1];
        minl = (lat[0] < lat[1]) ? lat[0] : lat[1];
        start = 1'b1; op = o; br = b; d = dd;
        @(negedge clk);
        for (int k = 0; k <= maxl + 1; k++) begin
            if (k > 0) @(negedge clk);
            start = 1'b0;
            op = 4'($urandom); br = 16'($urandom); d = 4'($urandom);
            for (int i = 0; i < 2; i++) begin
                n_cmp++;
                if (done_o[i] !== (k == lat[i])) begin
                    n_fail++;
                    $display("FAIL %s done dut%0d k=%0d: got %b expected %b", name, i, k, done_o[i], (k == lat[i]));
                end
                n_cmp++;
                if (busy_o[i] !== (k <= lat[i])) begin
                    n_fail++;
                    $display("FAIL %s busy dut%0d k=%0d: got %b expected %b", name, i, k, busy_o[i], (k <= lat[i]));
                end
                if (k == lat[i]) begin
                    last_out[i]  = er;
                    last_szcv[i] = ef;
                end
                n_cmp++;
                if (out_o[i] !== last_out[i] || szcv_o[i] !== last_szcv[i]) begin
                    n_fail++;
                    $display("FAIL %s result dut%0d k=%0d: got out=%h szcv=%b expected out=%h szcv=%b",
                             name, i, k, out_o[i], szcv_o[i], last_out[i], last_szcv[i]);
                end
            end
            // Stray starts while both instances are still busy must be ignored
            if (interfere && k <= minl && (k == 1 || k == minl)) start = 1'b1;
        end
        start = 1'b0;
    endtask

    task automatic check_const(input string name, input logic [15:0] eo, input logic [3:0] ef);
        for (int i = 0; i < 2; i++) begin
            n_cmp++;
            if (last_out[i] !== eo || last_szcv[i] !== ef || out_o[i] !== eo || szcv_o[i] !== ef) begin
                n_fail++;
                $display("FAIL %s dut%0d: got out=%h szcv=%b expected out=%h szcv=%b",
                         name, i, out_o[i], szcv_o[i], eo, ef);
            end
        end
    endtask

    task automatic test_reset();
        for (int i = 0; i < 2; i++) begin
            n_cmp++;
            if (busy_o[i] !== 1'b0 || done_o[i] !== 1'b0 || out_o[i] !== 16'h0 || szcv_o[i] !== 4'h0) begin
                n_fail++;
                $display("FAIL reset dut%0d: got busy=%b done=%b out=%h szcv=%b expected all zero",
                         i, busy_o[i], done_o[i], out_o[i], szcv_o[i]);
            end
            last_out[i]  = 16'h0;
            last_szcv[i] = 4'h0;
        end
    endtask

    task automatic test_directed();
        run_op("sll_1", 4'b1000, 16'h8001, 4'd1, 1'b0);
        check_const("sll_1_val", 16'h0002, 4'b0010);
        run_op("sra_15", 4'b1011, 16'h8000, 4'd15, 1'b0);
        check_const("sra_15_val", 16'hFFFF, 4'b1000);
        run_op("srl_1", 4'b1010, 16'h0001, 4'd1, 1'b0);
        check_const("srl_1_val", 16'h0000, 4'b0110);
        run_op("slr_4", 4'b1001, 16'h1234, 4'd4, 1'b0);
        check_const("slr_4_val", 16'h2341, 4'b0000);
        run_op("sll_d0", 4'b1000, 16'hABCD, 4'd0, 1'b0);
        check_const("sll_d0_val", 16'hABCD, 4'b1000);
        run_op("nonshift", 4'b0000, 16'hFFFF, 4'd5, 1'b0);
        check_const("nonshift_val", 16'h0000, 4'b0000);
    endtask

    task automatic test_handshake();
        run_op("handshake", 4'b1010, 16'hF000, 4'd12, 1'b1);
        check_const("handshake_val", 16'h000F, 4'b0000);
    endtask

    task automatic test_reset_mid();
        start = 1'b1; op = 4'b1000; br = 16'($urandom); d = 4'd10;
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        for (int i = 0; i < 2; i++) begin
            n_cmp++;
            if (busy_o[i] !== 1'b0 || done_o[i] !== 1'b0 || out_o[i] !== 16'h0 || szcv_o[i] !== 4'h0) begin
                n_fail++;
                $display("FAIL reset_mid dut%0d: got busy=%b done=%b out=%h szcv=%b expected all zero",
                         i, busy_o[i], done_o[i], out_o[i], szcv_o[i]);
            end
            last_out[i]  = 16'h0;
            last_szcv[i] = 4'h0;
        end
        #1 rst_n = 1'b1;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            for (int i = 0; i < 2; i++) begin
                n_cmp++;
                if (done_o[i] !== 1'b0 || busy_o[i] !== 1'b0) begin
                    n_fail++;
                    $display("FAIL reset_mid_idle dut%0d k=%0d: got busy=%b done=%b expected 0 0",
                             i, k, busy_o[i], done_o[i]);
                end
            end
        end
        run_op("after_reset", 4'b1000, 16'h0003, 4'd2, 1'b0);
        check_const("after_reset_val", 16'h000C, 4'b0000);
    endtask

    task automatic test_back_to_back();
        logic [3:0] o;
        for (int n = 0; n < 40; n++) begin
            if ($urandom_range(0, 4) == 0) o = 4'($urandom);
            else o = {2'b10, 2'($urandom)};
            run_op("random", o, 16'($urandom), 4'($urandom), 1'($urandom));
        end
    endtask

    initial begin
        n_cmp = 0;
        n_fail = 0;
        steps[0] = STEP_A;
        steps[1] = STEP_B;
        rst_n = 1'b0;
        start = 1'b0;
        op = 4'h0;
        br = 16'h0;
        d = 4'h0;
        repeat (2) @(negedge clk);
        test_reset();
        rst_n = 1'b1;
        @(negedge clk);
        test_directed();
        test_handshake();
        test_reset_mid();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
